// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller and its lane aligner.
package dmem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr,
        StDone
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } dmem_size_e;

    localparam logic [0:31] BUS_ERR_DATA = '0;

    // Byte wins when both size strobes are set.
    function automatic dmem_size_e decode_size(input logic is_byte, input logic is_half);
        if (is_byte) begin
            return SZ_BYTE;
        end else if (is_half) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input dmem_size_e size, input logic [0:1] offset);
        case (size)
            SZ_HALF: return offset[1];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [0:1]  offset_i,
    input  dmem_size_e  size_i,
    input  logic        sign_extend_i,
    input  logic [0:31] rdata_i,
    input  logic [0:31] wdata_i,
    output logic [0:31] load_data_o,
    output logic [0:31] merged_o
);

    logic [0:7]  lane;
    logic [0:15] half;

    always_comb begin
        lane = rdata_i[0:7];
        unique case (offset_i)
            2'd0: lane = rdata_i[0:7];
            2'd1: lane = rdata_i[8:15];
            2'd2: lane = rdata_i[16:23];
            2'd3: lane = rdata_i[24:31];
        endcase
        half = offset_i[0] ? rdata_i[16:31] : rdata_i[0:15];
    end

    always_comb begin
        load_data_o = rdata_i;
        merged_o    = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{sign_extend_i & lane[0]}}, lane};
                unique case (offset_i)
                    2'd0: merged_o[0:7]   = wdata_i[24:31];
                    2'd1: merged_o[8:15]  = wdata_i[24:31];
                    2'd2: merged_o[16:23] = wdata_i[24:31];
                    2'd3: merged_o[24:31] = wdata_i[24:31];
                endcase
            end
            SZ_HALF: begin
                load_data_o = {{16{sign_extend_i & half[0]}}, half};
                if (offset_i[0]) begin
                    merged_o[16:31] = wdata_i[16:31];
                end else begin
                    merged_o[0:15] = wdata_i[16:31];
                end
            end
            default: begin
                load_data_o = rdata_i;
                merged_o    = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// DMEM port to word-wide req/ack SRAM: alignment, extension, sub-word RMW,
// pipeline stall, misalign and timeout reporting.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        proc_req,
    input  logic [0:31] addr_from_proc,
    input  logic [0:31] data_from_proc,
    input  logic        write_enable_from_proc,
    input  logic        byte_from_proc,
    input  logic        half_word_from_proc,
    input  logic        sign_extend_from_proc,
    output logic [0:31] data_to_proc,
    output logic        stall_to_proc,
    output logic        done_to_proc,
    output logic        misalign_to_proc,
    output logic        bus_err_to_proc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wdata,
    input  logic [0:31] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    dmem_state_e    state_q, state_d;
    logic [0:31]    addr_q, addr_d;
    dmem_size_e     size_q, size_d;
    logic           sign_q, sign_d;
    logic [0:31]    wdata_q, wdata_d;
    logic [0:31]    data_q, data_d;
    logic           misalign_q, misalign_d;
    logic           bus_err_q, bus_err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    dmem_size_e  req_size;
    logic        req_misalign;
    logic [0:31] load_data;
    logic [0:31] merged_word;

    assign req_size     = decode_size(byte_from_proc, half_word_from_proc);
    assign req_misalign = is_misaligned(req_size, addr_from_proc[30:31]);

    dmem_lane_align u_lane_align (
        .offset_i      (addr_q[30:31]),
        .size_i        (size_q),
        .sign_extend_i (sign_q),
        .rdata_i       (mem_rdata),
        .wdata_i       (wdata_q),
        .load_data_o   (load_data),
        .merged_o      (merged_word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        sign_d     = sign_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (proc_req) begin
                    addr_d     = addr_from_proc;
                    size_d     = req_size;
                    sign_d     = sign_extend_from_proc;
                    wdata_d    = data_from_proc;
                    misalign_d = 1'b0;
                    bus_err_d  = 1'b0;
                    cnt_d      = '0;
                    if (req_misalign) begin
                        misalign_d = 1'b1;
                        data_d     = BUS_ERR_DATA;
                        state_d    = StDone;
                    end else if (!write_enable_from_proc) begin
                        state_d = StRd;
                    end else if (req_size == SZ_WORD) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd, StWr, StRmwRd, StRmwWr: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if (state_q == StRd) begin
                        data_d  = load_data;
                        state_d = StDone;
                    end else if (state_q == StRmwRd) begin
                        // The merged word becomes the write data of the second handshake.
                        wdata_d = merged_word;
                        state_d = StRmwWr;
                    end else begin
                        state_d = StDone;
                    end
                end else if (cnt_q == CntMax) begin
                    bus_err_d = 1'b1;
                    data_d    = BUS_ERR_DATA;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            size_q     <= SZ_WORD;
            sign_q     <= 1'b0;
            wdata_q    <= '0;
            data_q     <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        mem_req = (state_q == StRd) || (state_q == StWr) ||
                  (state_q == StRmwRd) || (state_q == StRmwWr);
        mem_we  = (state_q == StWr) || (state_q == StRmwWr);
        stall_to_proc = ((state_q != StIdle) && (state_q != StDone)) ||
                        ((state_q == StIdle) && proc_req);
        done_to_proc     = (state_q == StDone);
        misalign_to_proc = misalign_q;
        bus_err_to_proc  = bus_err_q;
        data_to_proc     = data_q;
        mem_addr         = {addr_q[0:29], 2'b00};
        mem_wdata        = wdata_q;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed accesses against a latency-programmable memory.
module tb_dmem_ctrl;

    logic        clock;
    logic        reset;
    logic        proc_req;
    logic [0:31] addr_from_proc;
    logic [0:31] data_from_proc;
    logic        write_enable_from_proc;
    logic        byte_from_proc;
    logic        half_word_from_proc;
    logic        sign_extend_from_proc;
    logic [0:31] data_to_proc;
    logic        stall_to_proc;
    logic        done_to_proc;
    logic        misalign_to_proc;
    logic        bus_err_to_proc;
    logic        mem_req;
    logic        mem_we;
    logic [0:31] mem_addr;
    logic [0:31] mem_wdata;
    logic [0:31] mem_rdata;
    logic        mem_ack;

    dmem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .proc_req               (proc_req),
        .addr_from_proc         (addr_from_proc),
        .data_from_proc         (data_from_proc),
        .write_enable_from_proc (write_enable_from_proc),
        .byte_from_proc         (byte_from_proc),
        .half_word_from_proc    (half_word_from_proc),
        .sign_extend_from_proc  (sign_extend_from_proc),
        .data_to_proc           (data_to_proc),
        .stall_to_proc          (stall_to_proc),
        .done_to_proc           (done_to_proc),
        .misalign_to_proc       (misalign_to_proc),
        .bus_err_to_proc        (bus_err_to_proc),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_rdata              (mem_rdata),
        .mem_ack                (mem_ack)
    );

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        berr;
        int          lat;
        int          start;
        int          hs;
        logic        rs;
        logic        ws;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Stimulus-owned configuration and handshake expectations.
    int          lat_cfg[2];
    logic [31:0] rd_cfg[2];
    logic        we_cfg[2];
    logic [31:0] wd_cfg[2];
    logic [31:0] addr_cfg;
    int          acc_id = 0;
    int          pulse_req = 0;
    int          lost = 0;
    int          cur_start = 0;
    int          cur_lat = 0;
    logic        in_access = 1'b0;
    logic        expect_quiet = 1'b1;

    // Monitor/responder-owned state.
    int   resp_id = 0;
    int   pulse_done = 0;
    int   lost_seen = 0;
    int   hs_cnt = 0;
    int   wait_cnt = 0;
    logic req_seen = 1'b0;
    logic we_seen = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and memory responder share one process so only it steps the counters.
    initial begin
        exp_t e;
        logic exp_stall;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            #1;
            if (resp_id != acc_id) begin
                resp_id  = acc_id;
                hs_cnt   = 0;
                wait_cnt = 0;
                req_seen = 1'b0;
                we_seen  = 1'b0;
            end
            mem_ack = 1'b0;

            if (expect_quiet) begin
                chk("quiet_mem_req", 32'(mem_req), 32'd0);
                chk("quiet_mem_we", 32'(mem_we), 32'd0);
                chk("quiet_mem_addr", mem_addr, 32'd0);
                chk("quiet_mem_wdata", mem_wdata, 32'd0);
                chk("quiet_data", data_to_proc, 32'd0);
                chk("quiet_done", 32'(done_to_proc), 32'd0);
                chk("quiet_misalign", 32'(misalign_to_proc), 32'd0);
                chk("quiet_bus_err", 32'(bus_err_to_proc), 32'd0);
                chk("quiet_stall", 32'(stall_to_proc), 32'd0);
            end else begin
                exp_stall = in_access && ((cyc - cur_start) < cur_lat);
                chk("stall", 32'(stall_to_proc), 32'(exp_stall));
            end

            if (lost != lost_seen) begin
                lost_seen = lost;
                chk("done_timeout", 32'd0, 32'd1);
                if (sb.size() > 0) void'(sb.pop_front());
            end

            if (done_to_proc) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done_to_proc), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.start), 32'(e.lat));
                    if (e.chk_data) chk("data", data_to_proc, e.data);
                    chk("misalign", 32'(misalign_to_proc), 32'(e.mis));
                    chk("bus_err", 32'(bus_err_to_proc), 32'(e.berr));
                    chk("handshakes", 32'(hs_cnt), 32'(e.hs));
                    chk("req_seen", 32'(req_seen), 32'(e.rs));
                    chk("we_seen", 32'(we_seen), 32'(e.ws));
                end
            end

            if (mem_req) begin
                req_seen = 1'b1;
                if (mem_we) we_seen = 1'b1;
                if (hs_cnt < 2 && wait_cnt == lat_cfg[hs_cnt]) begin
                    chk("hs_we", 32'(mem_we), 32'(we_cfg[hs_cnt]));
                    chk("hs_addr", mem_addr, addr_cfg);
                    if (we_cfg[hs_cnt]) chk("hs_wdata", mem_wdata, wd_cfg[hs_cnt]);
                    mem_ack   = 1'b1;
                    mem_rdata = rd_cfg[hs_cnt];
                    hs_cnt++;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (pulse_req != pulse_done) begin
                mem_ack = 1'b1;
                pulse_done++;
            end
        end
    end

    task automatic setup(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic bt, input logic hw, input logic sx,
                         input int l0, input logic [31:0] r0, input int l1,
                         input logic [31:0] r1, input logic [31:0] wd1);
        lat_cfg[0] = l0;
        rd_cfg[0]  = r0;
        lat_cfg[1] = l1;
        rd_cfg[1]  = r1;
        addr_cfg   = a & ~32'd3;
        we_cfg[0]  = we && !(bt || hw);
        wd_cfg[0]  = d;
        we_cfg[1]  = 1'b1;
        wd_cfg[1]  = wd1;
        addr_from_proc         = a;
        data_from_proc         = d;
        write_enable_from_proc = we;
        byte_from_proc         = bt;
        half_word_from_proc    = hw;
        sign_extend_from_proc  = sx;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic bt, input logic hw, input logic sx,
                         input int l0, input logic [31:0] r0, input int l1,
                         input logic [31:0] r1, input logic [31:0] wd1,
                         input logic [31:0] xd, input logic xchk, input logic xmis,
                         input logic xberr, input int xlat, input int xhs,
                         input logic xrs, input logic xws);
        exp_t e;
        logic got;
        int   n;
        @(negedge clock);
        setup(a, d, we, bt, hw, sx, l0, r0, l1, r1, wd1);
        e.data = xd;  e.chk_data = xchk;  e.mis = xmis;  e.berr = xberr;
        e.lat = xlat; e.start = cyc;      e.hs = xhs;    e.rs = xrs;  e.ws = xws;
        sb.push_back(e);
        cur_start = cyc;
        cur_lat   = xlat;
        in_access = 1'b1;
        proc_req  = 1'b1;
        acc_id++;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clock);
            n++;
            if (done_to_proc) got = 1'b1;
        end
        proc_req  = 1'b0;
        in_access = 1'b0;
        if (!got) lost++;
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        proc_req = 1'b0;
        setup(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 0, 32'h0, 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        expect_quiet = 1'b0;

        //     addr      wdata         we bt hw sx l0   rd0           l1   rd1 wd1
        //     exp data      chk mis berr lat hs rs ws
        issue(32'h100, 32'h0,        0, 0, 0, 0, 2,   32'h89ABCDEF, 0,   0, 0,
              32'h89ABCDEF, 1, 0, 0, 4, 1, 1, 0);
        issue(32'h102, 32'h0,        0, 1, 0, 1, 0,   32'h1122F344, 0,   0, 0,
              32'hFFFFFFF3, 1, 0, 0, 2, 1, 1, 0);
        issue(32'h102, 32'h0,        0, 1, 0, 0, 0,   32'h1122F344, 0,   0, 0,
              32'h000000F3, 1, 0, 0, 2, 1, 1, 0);
        issue(32'h202, 32'h1234BEEF, 1, 0, 1, 0, 0,   32'h11223344, 0,   0, 32'h1122BEEF,
              32'h0,        0, 0, 0, 3, 2, 1, 1);
        issue(32'h101, 32'h0,        0, 0, 1, 0, 0,   32'h0,        0,   0, 0,
              32'h0,        0, 1, 0, 1, 0, 0, 0);
        issue(32'h300, 32'h0,        0, 0, 0, 0, 200, 32'h0,        0,   0, 0,
              32'h0,        1, 0, 1, 9, 0, 1, 0);
        issue(32'h204, 32'hDEADBEEF, 1, 0, 0, 0, 1,   32'h0,        0,   0, 0,
              32'h0,        0, 0, 0, 3, 1, 1, 1);
        issue(32'h400, 32'h0,        0, 0, 1, 1, 0,   32'h80017FFF, 0,   0, 0,
              32'hFFFF8001, 1, 0, 0, 2, 1, 1, 0);
        issue(32'h403, 32'h00000055, 1, 1, 0, 0, 1,   32'hAABBCCDD, 1,   0, 32'hAABBCC55,
              32'h0,        0, 0, 0, 5, 2, 1, 1);
        issue(32'h101, 32'h0,        0, 1, 1, 0, 0,   32'h1122F344, 0,   0, 0,
              32'h00000022, 1, 0, 0, 2, 1, 1, 0);

        // Reset while the RMW write is outstanding, then a stray ack after release.
        @(negedge clock);
        setup(32'h600, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h01020304, 200, 32'h0, 32'h0);
        cur_start = cyc;
        cur_lat   = 1000;
        in_access = 1'b1;
        proc_req  = 1'b1;
        acc_id++;
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!(mem_req && mem_we)) lost++;
        reset        = 1'b0;
        proc_req     = 1'b0;
        in_access    = 1'b0;
        expect_quiet = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulse_req++;
        repeat (5) @(negedge clock);
        expect_quiet = 1'b0;

        issue(32'h102, 32'h0,        0, 0, 0, 0, 0,   32'h0,        0,   0, 0,
              32'h0,        0, 1, 0, 1, 0, 0, 0);
        issue(32'h500, 32'h000000AB, 1, 1, 0, 0, 0,   32'h12345678, 200, 0, 0,
              32'h0,        1, 0, 1, 10, 1, 1, 1);
        issue(32'h504, 32'h000000AB, 1, 1, 0, 0, 200, 32'h0,        0,   0, 0,
              32'h0,        1, 0, 1, 9, 0, 1, 0);
        issue(32'h104, 32'h0,        0, 0, 0, 1, 0,   32'h7FFFFFFF, 0,   0, 0,
              32'h7FFFFFFF, 1, 0, 0, 2, 1, 1, 0);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller between the processor's DMEM port (addr/byte/half-word/sign-extend signals from the MEM stage) and a word-wide, variable-latency data SRAM with a req/ack handshake. Performs big-endian lane alignment, sign and zero extension, and read-modify-write for sub-word stores. Stalls the pipeline while an access is outstanding. Reports misaligned accesses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles to wait for mem_ack before a bus error is declared (≥2).
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- proc_req  in  1  MEM stage holds a load/store this cycle
- addr_from_proc  in  [0:31]  byte address
- data_from_proc  in  [0:31]  store data, right-justified for byte/half stores
- write_enable_from_proc  in  1  1 = store, 0 = load
- byte_from_proc / half_word_from_proc  in  1 each  access size; both 0 = word; both 1 is treated as byte
- sign_extend_from_proc  in  1  sign-extend sub-word loads
- data_to_proc  out  [0:31]  load result, valid while done_to_proc=1
- stall_to_proc  out  1  freeze the pipeline
- done_to_proc  out  1  one-cycle completion strobe
- misalign_to_proc / bus_err_to_proc  out  1 each  error qualifiers, valid with done_to_proc
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write request
- mem_addr  out  [0:31]  word address, bits [30:31] always 0
- mem_wdata  out  [0:31]  full write word
- mem_rdata  in  [0:31]  read word, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE + proc_req:
  - If misaligned (half with addr[31]=1, or word with addr[30:31]≠0), go to DONE with misalign=1. No memory access.
  - Load → RD.
  - Word store → WR.
  - Byte or half store → RMW_RD.
- The request (address, size, data, sign) is latched on leaving IDLE. Inputs are ignored until the next IDLE.
- RD and RMW_RD: mem_req=1, mem_we=0.
  - On mem_ack, capture mem_rdata.
  - RD → DONE.
  - RMW_RD → RMW_WR with the merged word.
- WR and RMW_WR: mem_req=1, mem_we=1. On mem_ack → DONE.
- Lanes are big-endian; byte offset 0 = bits [0:7].
- Byte load:
  - Selected lane goes to [24:31].
  - Bits [0:23] are copies of bit 24 if sign_extend, else 0.
- Half load:
  - Offset 0 = [0:15], offset 2 = [16:31].
  - Result goes to [16:31] with extension as for byte loads.
- Store merge:
  - data_from_proc[24:31] or [16:31] replaces the addressed lane.
  - Other lanes come from the RMW read.
- Timeout:
  - Wait counter resets on entering each mem state and increments each cycle without ack.
  - At TIMEOUT_CYCLES, go to DONE with bus_err=1 and data_to_proc=0.
  - A timed-out RMW does not perform its write.
- DONE: done_to_proc=1 and stall_to_proc=0 for one cycle, then IDLE. A proc_req seen in DONE is the same access and is not restarted.
- mem_ack arriving in IDLE or DONE is ignored.

## Timing
- stall_to_proc = (state ∉ {IDLE, DONE}) | (state==IDLE & proc_req). It is combinational, so the pipeline freezes in the same cycle the request appears.
- Request in cycle 0 → mem_req rises in cycle 1.
  - Ack in cycle n → DONE in cycle n+1.
  - Minimum load or word store: 2 stall cycles, done in cycle 2.
- Sub-word store: two handshakes. Minimum: done in cycle 3.
- Misaligned access: done in cycle 1, no mem_req.
- mem_req drops in the cycle after ack. mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Reset (any time, including mid-RMW):
  - State → IDLE.
  - mem_req, mem_we, stall_to_proc (absent proc_req), done_to_proc, misalign_to_proc and bus_err_to_proc → 0.
  - data_to_proc, mem_addr and mem_wdata → 0.
  - Counter cleared. A pending ack after reset is discarded.

## Structure
- dmem_pkg holds:
  - the state enum
  - the access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the size-decode function
  - the BUS_ERR_DATA constant (0)
- Sub-module dmem_lane_align: a combinational extract/extend for loads and merge for stores, keyed by offset and size. It is instantiated once and reusable by a later cache.

## Test plan
- Word load at 0x100, mem_rdata=0x89ABCDEF, ack after 3 cycles → data_to_proc=0x89ABCDEF, done in cycle 4, stall high for cycles 0–3.
- Signed byte load at 0x102, memory word 0x1122F344 → 0xFFFFFFF3. The unsigned variant → 0x000000F3.
- Half store 0xXXXXBEEF at 0x202, memory word 0x11223344 → RMW read, then write 0x1122BEEF to mem_addr 0x200, done in cycle 3 with immediate acks.
- Half load at 0x101 → misalign_to_proc=1 in cycle 1, mem_req never asserted.
- With TIMEOUT_CYCLES=8 and no ack on a load → bus_err_to_proc=1 and data 0 in cycle 9.
- reset low during RMW_WR, then ack pulsed after release → outputs 0, state IDLE, no spurious done.
